// File: rtl/fractal_pixel_engine.sv
// Escape-time iterator for one pixel at a time, Mandelbrot or Julia mode, with valid/ready on both sides.
// Define FRACTAL_ESCAPE_MAG_EN to add the mag_sq output used for smooth colouring.
module fractal_pixel_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 13,
  parameter int COORD_WIDTH  = 8,
  parameter int ZOOM_WIDTH   = 3,
  parameter int MAX_ITER     = 127,
  parameter int OUTPUT_WIDTH = 7,
  parameter int MUL_LATENCY  = 1,
  localparam int ITER_WIDTH  = $clog2(MAX_ITER + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [COORD_WIDTH-1:0]       px,
  input  logic [COORD_WIDTH-1:0]       py,
  input  logic signed [DATA_WIDTH-1:0] origin_re,
  input  logic signed [DATA_WIDTH-1:0] origin_im,
  input  logic [ZOOM_WIDTH-1:0]        zoom,
  input  logic                         julia,
  input  logic signed [DATA_WIDTH-1:0] k_re,
  input  logic signed [DATA_WIDTH-1:0] k_im,
  input  logic [ITER_WIDTH-1:0]        max_iter,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ITER_WIDTH-1:0]        iters,
  output logic                         escaped,
`ifdef FRACTAL_ESCAPE_MAG_EN
  output logic [DATA_WIDTH+2:0]        mag_sq,
`endif
  output logic [OUTPUT_WIDTH-1:0]      shade
);

  // state   | meaning
  // S_IDLE  | waiting for a pixel request
  // S_MUL   | waiting for the squared/cross products of z
  // S_CHECK | escape / limit test, otherwise advance z
  // S_DONE  | result presented until out_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH + 1;
  localparam int UW = 2 * DATA_WIDTH + 2;
  localparam logic [SW-1:0] FOUR = SW'(1) << (2 * FRAC_BITS + 2);

  logic [1:0]                   state;
  logic [1:0]                   wait_cnt;
  logic signed [DATA_WIDTH-1:0] z_re, z_im, c_re, c_im;
  logic [ITER_WIDTH-1:0]        count, limit;

  logic signed [PW-1:0] rr_pipe [MUL_LATENCY];
  logic signed [PW-1:0] ii_pipe [MUL_LATENCY];
  logic signed [PW-1:0] ri_pipe [MUL_LATENCY];
  logic signed [PW-1:0] rr, ii, ri;
  logic [SW-1:0]        mag_full;
  logic                 escape;
  logic signed [UW-1:0] diff, twice, nre, nim;
  logic [DATA_WIDTH-1:0] p_re, p_im;
  logic [ITER_WIDTH-1:0] limit_in;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign p_re = origin_re + (DATA_WIDTH'(px) << zoom);
  assign p_im = origin_im + (DATA_WIDTH'(py) << zoom);
  assign limit_in = (max_iter > ITER_WIDTH'(MAX_ITER)) ? ITER_WIDTH'(MAX_ITER) : max_iter;

  // z is held constant while in S_MUL, so the last stage is valid after MUL_LATENCY edges.
  always_ff @(posedge clk) begin
    rr_pipe[0] <= z_re * z_re;
    ii_pipe[0] <= z_im * z_im;
    ri_pipe[0] <= z_re * z_im;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      rr_pipe[i] <= rr_pipe[i-1];
      ii_pipe[i] <= ii_pipe[i-1];
      ri_pipe[i] <= ri_pipe[i-1];
    end
  end

  assign rr = rr_pipe[MUL_LATENCY-1];
  assign ii = ii_pipe[MUL_LATENCY-1];
  assign ri = ri_pipe[MUL_LATENCY-1];

  assign mag_full = {1'b0, rr} + {1'b0, ii};
  assign escape   = (mag_full >= FOUR);

  assign diff  = {{2{rr[PW-1]}}, rr} - {{2{ii[PW-1]}}, ii};
  assign twice = {ri[PW-1], ri, 1'b0};
  assign nre   = (diff >>> FRAC_BITS) + UW'(c_re);
  assign nim   = (twice >>> FRAC_BITS) + UW'(c_im);

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [UW-1:0] v);
    if ((&v[UW-1:DATA_WIDTH-1]) || !(|v[UW-1:DATA_WIDTH-1]))
      sat = v[DATA_WIDTH-1:0];
    else
      sat = {v[UW-1], {(DATA_WIDTH-1){~v[UW-1]}}};
  endfunction

`ifdef FRACTAL_ESCAPE_MAG_EN
  logic [SW-1:0]         mag_shift;
  logic [DATA_WIDTH+2:0] mag_sat;
  assign mag_shift = mag_full >> FRAC_BITS;
  assign mag_sat   = (|mag_shift[SW-1:DATA_WIDTH+3]) ? '1 : mag_shift[DATA_WIDTH+2:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      z_re     <= '0;
      z_im     <= '0;
      c_re     <= '0;
      c_im     <= '0;
      count    <= '0;
      limit    <= '0;
      iters    <= '0;
      escaped  <= 1'b0;
      shade    <= '0;
`ifdef FRACTAL_ESCAPE_MAG_EN
      mag_sq   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          z_re     <= julia ? p_re : '0;
          z_im     <= julia ? p_im : '0;
          c_re     <= julia ? k_re : p_re;
          c_im     <= julia ? k_im : p_im;
          count    <= '0;
          limit    <= limit_in;
          wait_cnt <= 2'(MUL_LATENCY - 1);
          state    <= S_MUL;
        end
        S_MUL: begin
          if (wait_cnt == 2'd0) state <= S_CHECK;
          else wait_cnt <= wait_cnt - 2'd1;
        end
        S_CHECK: begin
          if (escape || count == limit) begin
            iters   <= count;
            escaped <= escape;
            shade   <= escape ? OUTPUT_WIDTH'(count >> (ITER_WIDTH - OUTPUT_WIDTH)) : '1;
`ifdef FRACTAL_ESCAPE_MAG_EN
            mag_sq  <= mag_sat;
`endif
            state   <= S_DONE;
          end else begin
            z_re     <= sat(nre);
            z_im     <= sat(nim);
            count    <= count + 1'b1;
            wait_cnt <= 2'(MUL_LATENCY - 1);
            state    <= S_MUL;
          end
        end
        default: if (out_ready) state <= S_IDLE;
      endcase
    end
  end

endmodule
